// File: rtl/dispense_pkg.sv
// Shared colour codes, sequencer states and default timing for the dispense sequencer.
// The colour helper picks the next chip colour in red, green, blue priority.
package dispense_pkg;

  localparam logic [1:0] COL_RED   = 2'b00;
  localparam logic [1:0] COL_GREEN = 2'b01;
  localparam logic [1:0] COL_BLUE  = 2'b10;
  localparam logic [1:0] COL_NONE  = 2'b11;

  localparam int unsigned DEF_PARK_CYCLES    = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 100_000_000;
  localparam int unsigned DEF_CNT_W          = 4;
  localparam int unsigned WD_W               = 27;
  localparam int unsigned REM_W              = 6;

  typedef enum logic [2:0] {
    StIdle,
    StPark,
    StIssue,
    StWaitClr,
    StWaitDone,
    StNext,
    StDone,
    StFault
  } seq_state_e;

  function automatic logic [1:0] first_colour(input logic red_nz, input logic green_nz,
                                              input logic blue_nz);
    if (red_nz) begin
      return COL_RED;
    end else if (green_nz) begin
      return COL_GREEN;
    end else if (blue_nz) begin
      return COL_BLUE;
    end
    return COL_NONE;
  endfunction

endpackage

// File: rtl/dispense_sequencer_if.sv
// Upstream order/status handshake plus the dispenser command lines, bundled as one bus.
// master is the controller/dispenser side, slave is the sequencer.
interface dispense_sequencer_if #(
  parameter int unsigned CNT_W = 4
);

  logic             order_valid;
  logic             order_ready;
  logic [CNT_W-1:0] red_count;
  logic [CNT_W-1:0] green_count;
  logic [CNT_W-1:0] blue_count;
  logic             abort;
  logic             clear_fault;
  logic [1:0]       disp_code;
  logic             disp_start;
  logic             disp_complete;
  logic             busy;
  logic [5:0]       remaining;
  logic             order_done;
  logic             order_aborted;
  logic             fault;

  modport master (
    output order_valid, red_count, green_count, blue_count, abort, clear_fault, disp_complete,
    input  order_ready, disp_code, disp_start, busy, remaining, order_done, order_aborted, fault
  );

  modport slave (
    input  order_valid, red_count, green_count, blue_count, abort, clear_fault, disp_complete,
    output order_ready, disp_code, disp_start, busy, remaining, order_done, order_aborted, fault
  );

endinterface

// File: rtl/dispense_watchdog.sv
// Saturating cycle counter with clear/enable; o_expired flags the enabled cycle whose
// increment reaches TIMEOUT_CYCLES (and every enabled cycle after, while saturated).
module dispense_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned W              = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = i_en && (r_cnt >= (LIMIT - W'(1)));

endmodule

// File: rtl/dispense_sequencer.sv
// Order-level controller: turns one red/green/blue order into single-chip dispenser
// commands, parking the code at 11 between chips so every request is a code change.
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int unsigned PARK_CYCLES    = DEF_PARK_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 reset_n,
  dispense_sequencer_if.slave io_bus
);

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_red;
  logic [CNT_W-1:0] r_green;
  logic [CNT_W-1:0] r_blue;
  logic [1:0]       r_colour;
  logic             r_abort;
  logic [REM_W-1:0] r_remaining;
  logic             r_order_ready;
  logic [1:0]       r_disp_code;
  logic             r_disp_start;
  logic             r_busy;
  logic             r_order_done;
  logic             r_order_aborted;
  logic             r_fault;

  logic             w_in_wait;
  logic             w_in_park;
  logic             w_wd_expired;
  logic             w_park_done;
  logic [REM_W-1:0] w_sum;
  logic [1:0]       w_colour;

  assign w_in_wait = (r_state == StWaitClr) || (r_state == StWaitDone);
  assign w_in_park = (r_state == StPark);
  assign w_sum     = REM_W'(io_bus.red_count) + REM_W'(io_bus.green_count)
                   + REM_W'(io_bus.blue_count);
  assign w_colour  = first_colour(r_red != '0, r_green != '0, r_blue != '0);

  // Cleared outside the wait states, so ISSUE always starts a fresh chip budget.
  dispense_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .W             (WD_W)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (!w_in_wait),
    .i_en     (w_in_wait),
    .o_expired(w_wd_expired)
  );

  dispense_watchdog #(
    .TIMEOUT_CYCLES(PARK_CYCLES),
    .W             (WD_W)
  ) u_park_hold (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (!w_in_park),
    .i_en     (w_in_park),
    .o_expired(w_park_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= StIdle;
      r_red           <= '0;
      r_green         <= '0;
      r_blue          <= '0;
      r_colour        <= COL_NONE;
      r_abort         <= 1'b0;
      r_remaining     <= '0;
      r_order_ready   <= 1'b1;
      r_disp_code     <= COL_NONE;
      r_disp_start    <= 1'b0;
      r_busy          <= 1'b0;
      r_order_done    <= 1'b0;
      r_order_aborted <= 1'b0;
      r_fault         <= 1'b0;
    end else begin
      r_order_done <= 1'b0;
      if (r_busy && io_bus.abort) begin
        r_abort <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (io_bus.order_valid && r_order_ready) begin
            r_red       <= io_bus.red_count;
            r_green     <= io_bus.green_count;
            r_blue      <= io_bus.blue_count;
            r_remaining <= w_sum;
            r_abort     <= 1'b0;
            if (w_sum == '0) begin
              // Empty order completes immediately without leaving IDLE.
              r_order_done    <= 1'b1;
              r_order_aborted <= 1'b0;
            end else begin
              r_state       <= StPark;
              r_busy        <= 1'b1;
              r_order_ready <= 1'b0;
            end
          end
        end

        StPark: begin
          if (w_park_done) begin
            r_state      <= StIssue;
            r_colour     <= w_colour;
            r_disp_code  <= w_colour;
            r_disp_start <= 1'b1;
          end
        end

        StIssue: begin
          r_state <= StWaitClr;
        end

        StWaitClr: begin
          if (!io_bus.disp_complete) begin
            r_state <= StWaitDone;
          end else if (w_wd_expired) begin
            r_state      <= StFault;
            r_disp_code  <= COL_NONE;
            r_disp_start <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b1;
          end
        end

        StWaitDone: begin
          // A completion in the expiry cycle still counts as a good chip.
          if (io_bus.disp_complete) begin
            unique case (r_colour)
              COL_RED:   r_red   <= r_red - CNT_W'(1);
              COL_GREEN: r_green <= r_green - CNT_W'(1);
              COL_BLUE:  r_blue  <= r_blue - CNT_W'(1);
              default:   ;
            endcase
            r_remaining  <= r_remaining - REM_W'(1);
            r_disp_start <= 1'b0;
            r_state      <= StNext;
          end else if (w_wd_expired) begin
            r_state      <= StFault;
            r_disp_code  <= COL_NONE;
            r_disp_start <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b1;
          end
        end

        StNext: begin
          r_disp_code <= COL_NONE;
          if (r_abort || (r_remaining == '0)) begin
            r_state         <= StDone;
            r_order_done    <= 1'b1;
            r_order_aborted <= r_abort;
          end else begin
            r_state <= StPark;
          end
        end

        StDone: begin
          r_red         <= '0;
          r_green       <= '0;
          r_blue        <= '0;
          r_remaining   <= '0;
          r_abort       <= 1'b0;
          r_busy        <= 1'b0;
          r_order_ready <= 1'b1;
          r_state       <= StIdle;
        end

        StFault: begin
          if (io_bus.clear_fault) begin
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_remaining   <= '0;
            r_abort       <= 1'b0;
            r_fault       <= 1'b0;
            r_order_ready <= 1'b1;
            r_state       <= StIdle;
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.order_ready   = r_order_ready;
  assign io_bus.disp_code     = r_disp_code;
  assign io_bus.disp_start    = r_disp_start;
  assign io_bus.busy          = r_busy;
  assign io_bus.remaining     = r_remaining;
  assign io_bus.order_done    = r_order_done;
  assign io_bus.order_aborted = r_order_aborted;
  assign io_bus.fault         = r_fault;

endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
- Order-level controller that sits between the game/bank controller and the single-chip dispenser.
- Accepts one order of up to 15 red, 15 green and 15 blue chips and issues single-chip dispense commands one at a time, in the order red, then green, then blue.
- Drives the dispenser's colour code and start inputs, and watches its complete output.
- Guarantees the colour code changes between consecutive chips, because the dispenser only latches a request on a code change.
- Provides watchdog timeout, abort and order status to the upstream controller.

Parameters:
- PARK_CYCLES, 2: cycles the idle code 2'b11 is held before each chip (minimum 1).
- TIMEOUT_CYCLES, 100_000_000: maximum cycles per chip from issue to complete (2 s at 50 MHz).
- CNT_W, 4: width of each per-colour count.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- order_valid  in  1  an order is presented on the count inputs.
- order_ready  out  1  sequencer can accept an order.
- red_count  in  CNT_W  red chips requested.
- green_count  in  CNT_W  green chips requested.
- blue_count  in  CNT_W  blue chips requested.
- abort  in  1  stop the order at the next chip boundary.
- clear_fault  in  1  clears a sticky fault and returns the block to IDLE.
- disp_code  out  2  to dispenser: 00 red, 01 green, 10 blue, 11 idle/none.
- disp_start  out  1  to dispenser start input.
- disp_complete  in  1  from dispenser: the previous chip is finished.
- busy  out  1  an order is in progress.
- remaining  out  6  sum of chips still to dispense in the current order.
- order_done  out  1  one-cycle pulse when an order finishes or is aborted.
- order_aborted  out  1  valid with order_done; 1 if the order ended by abort.
- fault  out  1  sticky watchdog timeout flag.

Behaviour:
- Reset (asynchronous, active-low) values:
  - state=IDLE, order_ready=1, disp_code=2'b11, disp_start=0.
  - busy=0, remaining=0, order_done=0, order_aborted=0, fault=0, all counters 0.
  - Reset mid-dispense forces the idle code and start low immediately. No recovery of the lost chip.
- Order acceptance:
  - An order is accepted on order_valid & order_ready in IDLE; the three counts are latched.
  - order_ready is 0 in every state except IDLE.
  - If all counts are zero: order_done pulses the next cycle with order_aborted=0, and the block stays in IDLE.
- States:
  - IDLE: wait for an accepted order.
  - PARK: disp_code=11, disp_start=0. Hold PARK_CYCLES cycles, then go to ISSUE. Colour selected is the first nonzero count in order red, green, blue.
  - ISSUE: drive disp_code=colour, disp_start=1. Clear the watchdog. Next state WAIT_CLR.
  - WAIT_CLR: hold code and start. Wait for disp_complete==0, which the dispenser clears on the code change, then go to WAIT_DONE.
  - WAIT_DONE: hold code and start. On disp_complete==1, decrement the selected count and remaining, then go to NEXT.
  - NEXT: disp_start=0.
    - If abort was seen or remaining==0: go to DONE.
    - Otherwise go to PARK.
  - DONE: pulse order_done for 1 cycle, with order_aborted=abort_latched. Zero the counts, then go to IDLE.
  - FAULT: disp_code=11, disp_start=0, fault=1. Stay until clear_fault==1, then go to IDLE with fault=0 and counts zeroed.
- Abort:
  - abort is latched in any busy state.
  - It is honoured only at NEXT, never mid-chip, so the servo always completes its cycle.
  - An abort in IDLE is ignored.
- Watchdog:
  - Counts every cycle in WAIT_CLR and WAIT_DONE.
  - When the count reaches TIMEOUT_CYCLES without leaving those states, go to FAULT. The order is lost; order_done does not pulse.
- Simultaneous events:
  - disp_complete rising in the same cycle as the watchdog expiry: complete wins.
  - clear_fault outside FAULT is ignored.
- Width rules:
  - remaining = red+green+blue, 6-bit, maximum 45.
  - Counts never underflow; only a nonzero colour is ever selected.
  - The watchdog is 27 bits and saturates.

Decomposition:
- Shared package dispense_pkg:
  - colour codes COL_RED=2'b00, COL_GREEN=2'b01, COL_BLUE=2'b10, COL_NONE=2'b11.
  - sequencer state encoding localparams.
  - default timing constants.
- One sub-module, dispense_watchdog: a clear/enable/expired saturating counter parameterised by TIMEOUT_CYCLES. Also reused by the PARK hold counter.

Test Plan:
- Order r=2,g=0,b=1; dispenser model asserts complete 20 cycles after each code change:
  - codes seen: 11,00,11,00,11,10,11.
  - exactly 3 start windows.
  - remaining steps 3→2→1→0.
  - order_done pulse with aborted=0.
- Order r=0,g=3,b=0 → the code returns to 11 between each green chip, and the model latches 3 distinct requests (same-colour repeat check).
- Order all zero → order_done the cycle after acceptance, busy never asserted, disp_start stays 0.
- Order b=4 with abort pulsed during the second chip's WAIT_DONE:
  - the second chip completes.
  - no third ISSUE.
  - order_done with aborted=1.
  - remaining returns to 0 in IDLE.
- Model never asserts complete, TIMEOUT_CYCLES=100:
  - FAULT 100 cycles after ISSUE.
  - disp_start=0, code=11, fault=1.
  - order_ready=0 until clear_fault, then 1.
- reset_n pulsed low mid-WAIT_DONE → same-cycle disp_start=0, code=11, order_ready=1; a new order after reset proceeds normally.
